rocketcpu_uart_fifo: RTL and testbench

- Wishbone slave UART (8N1) placed downstream of the SoC memory bus; it replaces the unbuffered serial peripheral at 0x0400_0000.
- A programmable baud divider drives both directions.
- An RX FIFO absorbs bytes while the SERV core is busy. SERV is slow bit-serial, so unbuffered input drops characters.
- A single TX holding stage stalls the bus ack until the transmitter can accept the byte.

---
 rtl/rocketcpu_uart_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_rocketcpu_uart_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_uart_fifo.sv
// Wishbone 8N1 UART: programmable divider, RX FIFO, single TX holding stage.
// Define ROCKETCPU_UART_RX_IRQ_EN to add o_irq and the IRQ_CTRL register at offset 3.
module rocketcpu_uart_fifo #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 104,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        ser_rx,
    output logic        ser_tx
`ifdef ROCKETCPU_UART_RX_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic                 ack_q;
    logic [31:0]          rdt_q;
    logic [DIV_WIDTH-1:0] div_q;
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 rx_s1_q, rx_s2_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic                 ovr_q, ferr_q;

    logic sel_data, sel_status, sel_div, sel_r3;
    logic tx_busy, accept, rd_pop, tx_load, st_clr, div_wr;
    logic rx_full, rx_not_empty, rx_push, rx_ferr_set, do_push, ovr_set;
    logic [31:0]          cnt32, div_wr32, rd_val, r3_val;
    logic [7:0]           fill8;
    logic [DIV_WIDTH-1:0] div_wr_val;
    logic                 unused_bits;

    assign sel_data     = (i_wb_adr[3:2] == 2'd0);
    assign sel_status   = (i_wb_adr[3:2] == 2'd1);
    assign sel_div      = (i_wb_adr[3:2] == 2'd2);
    assign sel_r3       = (i_wb_adr[3:2] == 2'd3);
    assign tx_busy      = (tx_state_q != TX_IDLE);
    // A DATA write is held off (no ack, no side effect) while a frame is still going out.
    assign accept       = i_wb_cyc && !ack_q && !(i_wb_we && sel_data && tx_busy);
    assign rx_not_empty = (count_q != '0);
    assign rx_full      = (count_q == CW'(FIFO_DEPTH));
    assign rd_pop       = accept && !i_wb_we && sel_data && rx_not_empty;
    assign tx_load      = accept && i_wb_we && sel_data;
    assign st_clr       = accept && !i_wb_we && sel_status;
    assign div_wr       = accept && i_wb_we && sel_div;
    assign do_push      = rx_push && (!rx_full || rd_pop);
    assign ovr_set      = rx_push && rx_full && !rd_pop;
    assign cnt32        = 32'(count_q);
    assign fill8        = (cnt32 > 32'd255) ? 8'hFF : cnt32[7:0];
    assign unused_bits  = &{1'b0, i_wb_adr[1:0], div_wr32[31:16]};

    always_comb begin
        div_wr32 = 32'(div_q);
        if (i_wb_sel[0]) div_wr32[7:0]   = i_wb_dat[7:0];
        if (i_wb_sel[1]) div_wr32[15:8]  = i_wb_dat[15:8];
        if (i_wb_sel[2]) div_wr32[23:16] = i_wb_dat[23:16];
        if (i_wb_sel[3]) div_wr32[31:24] = i_wb_dat[31:24];
        div_wr_val = div_wr32[DIV_WIDTH-1:0];
        if (div_wr_val < DIV_WIDTH'(4)) div_wr_val = DIV_WIDTH'(4);
    end

`ifdef ROCKETCPU_UART_RX_IRQ_EN
    logic       irq_en_q, irq_q;
    logic [7:0] irq_thr_q;
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_en_q  <= 1'b1;
            irq_thr_q <= 8'd1;
            irq_q     <= 1'b0;
        end else begin
            if (accept && i_wb_we && sel_r3) begin
                if (i_wb_sel[0]) irq_en_q  <= i_wb_dat[0];
                if (i_wb_sel[1]) irq_thr_q <= i_wb_dat[15:8];
            end
            irq_q <= irq_en_q && ((cnt32 >= 32'(irq_thr_q)) || ovr_q);
        end
    end
    assign o_irq  = irq_q;
    assign r3_val = {16'h0, irq_thr_q, 7'h0, irq_en_q};
`else
    assign r3_val = 32'h0;
`endif

    always_comb begin
        rd_val = 32'h0;
        case (i_wb_adr[3:2])
            2'd0:    rd_val = rx_not_empty ? {24'h0, mem_q[rptr_q]} : 32'h8000_0000;
            2'd1:    rd_val = {16'h0, fill8, 3'b000, ferr_q, ovr_q, tx_busy, rx_full, rx_not_empty};
            2'd2:    rd_val = 32'(div_q);
            default: rd_val = r3_val;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        if (tx_state_q == TX_IDLE) begin
            if (tx_load) begin
                tx_state_d = TX_START;
                tx_cnt_d   = div_q;
                tx_shift_d = i_wb_dat[7:0];
                tx_bit_d   = 3'd0;
            end
        end else if (tx_cnt_q == DIV_WIDTH'(1)) begin
            // Reload from the live divider so a DIV write lands at the next bit boundary.
            tx_cnt_d = div_q;
            case (tx_state_q)
                TX_START: tx_state_d = TX_DATA;
                TX_DATA: begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end else begin
            tx_cnt_d = tx_cnt_q - DIV_WIDTH'(1);
        end
    end

    assign ser_tx = (tx_state_q == TX_START) ? 1'b0 :
                    (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s2_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = div_q >> 1;
            end
            RX_START: if (rx_cnt_q == DIV_WIDTH'(1)) begin
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_cnt_d   = div_q;
                rx_bit_d   = 3'd0;
            end else rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
            RX_DATA: if (rx_cnt_q == DIV_WIDTH'(1)) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_cnt_d   = div_q;
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
            default: begin
                // Counter parked at zero marks "bad stop seen, waiting for idle line".
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) rx_state_d = RX_IDLE;
                end else if (rx_cnt_q == DIV_WIDTH'(1)) begin
                    if (rx_s2_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_cnt_d    = '0;
                    end
                end else rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
            end
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (do_push) mem_q[wptr_q] <= rx_shift_q;
    end

    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q      <= 1'b0;
            rdt_q      <= '0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ack_q      <= accept;
            rdt_q      <= accept ? rd_val : '0;
            if (div_wr) div_q <= div_wr_val;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_s1_q    <= ser_rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (rd_pop)  rptr_q <= rptr_q + AW'(1);
            count_q    <= count_q + CW'(do_push) - CW'(rd_pop);
            ovr_q      <= ovr_set ? 1'b1 : (st_clr ? 1'b0 : ovr_q);
            ferr_q     <= rx_ferr_set ? 1'b1 : (st_clr ? 1'b0 : ferr_q);
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
endmodule

// File: tb/tb_rocketcpu_uart_fifo.sv
// Bench for rocketcpu_uart_fifo: register vector table, directed serial sequences, random RX traffic vs a queue model.
module tb_rocketcpu_uart_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic        ser_rx = 1'b1;
    logic        ser_tx;
`ifdef ROCKETCPU_UART_RX_IRQ_EN
    logic        irq;
    localparam logic [31:0] R3_RST = 32'h0000_0101;
    localparam logic [31:0] R3_WR  = 32'h0000_FF01;
`else
    localparam logic [31:0] R3_RST = 32'h0;
    localparam logic [31:0] R3_WR  = 32'h0;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] mq[$];
    logic m_ovr = 1'b0;
    logic m_ferr = 1'b0;

    rocketcpu_uart_fifo #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(104), .DIV_WIDTH(16)) dut (
        .i_wb_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack),
        .ser_rx(ser_rx), .ser_tx(ser_tx)
`ifdef ROCKETCPU_UART_RX_IRQ_EN
        , .o_irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic [3:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clk);
        adr = a; we = w; dat = d; sel = s; cyc = 1'b1;
        n = 0;
        r = 32'hDEAD_DEAD;
        @(negedge clk);
        while (!ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ack) begin
            total++;
            bad++;
            $display("FAIL wb_timeout: no ack at adr 0x%0h after %0d cycles, ack required", a, n);
        end else r = rdt;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] r);
        wb(a, 1'b0, 32'h0, 4'hF, r);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb(a, 1'b1, d, s, dummy);
    endtask

    function automatic logic [31:0] m_status();
        int c = mq.size();
        return {16'h0, 8'(c), 3'b000, m_ferr, m_ovr, 1'b0, (c == DEPTH), (c != 0)};
    endfunction

    task automatic m_rx(input logic [7:0] b, input logic ok);
        if (!ok) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic read_data_chk(input string nm);
        logic [31:0] r, exp;
        rd(4'h0, r);
        if (mq.size() == 0) exp = 32'h8000_0000;
        else exp = {24'h0, mq.pop_front()};
        check(nm, r, exp);
    endtask

    task automatic read_stat_chk(input string nm);
        logic [31:0] r, exp;
        rd(4'h4, r);
        exp = m_status();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check(nm, r, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input logic ok, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return ok;
        return b[k-1];
    endfunction

    task automatic drive_frame(input logic [7:0] b, input logic ok, input int per);
        for (int i = 0; i < 10 * per; i++) begin
            @(negedge clk);
            ser_rx = frame_bit(b, ok, i / per);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok, input int per);
        drive_frame(b, ok, per);
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
        m_rx(b, ok);
    endtask

    typedef struct packed {
        logic [3:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    initial begin
        logic [31:0] r;
        logic [7:0]  txb;
        int          per;

        vecs[0]  = '{4'h4, 1'b0, 32'h0,         4'hF, 32'h0};
        vecs[1]  = '{4'h8, 1'b0, 32'h0,         4'hF, 32'd104};
        vecs[2]  = '{4'h0, 1'b0, 32'h0,         4'hF, 32'h8000_0000};
        vecs[3]  = '{4'hC, 1'b0, 32'h0,         4'hF, R3_RST};
        vecs[4]  = '{4'h8, 1'b1, 32'h2,         4'hF, 32'h0};
        vecs[5]  = '{4'h8, 1'b0, 32'h0,         4'hF, 32'h4};
        vecs[6]  = '{4'h8, 1'b1, 32'hFFFF_1234, 4'h1, 32'h0};
        vecs[7]  = '{4'h8, 1'b0, 32'h0,         4'hF, 32'h34};
        vecs[8]  = '{4'h8, 1'b1, 32'h0000_5600, 4'h2, 32'h0};
        vecs[9]  = '{4'h8, 1'b0, 32'h0,         4'hF, 32'h5634};
        vecs[10] = '{4'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[11] = '{4'h4, 1'b0, 32'h0,         4'hF, 32'h0};
        vecs[12] = '{4'hC, 1'b1, 32'h0000_FFFF, 4'hF, 32'h0};
        vecs[13] = '{4'hC, 1'b0, 32'h0,         4'hF, R3_WR};
        vecs[14] = '{4'h8, 1'b1, 32'h3,         4'hF, 32'h0};
        vecs[15] = '{4'h8, 1'b0, 32'h0,         4'hF, 32'h4};
        vecs[16] = '{4'h8, 1'b1, 32'h8,         4'hF, 32'h0};
        vecs[17] = '{4'h8, 1'b0, 32'h0,         4'hF, 32'h8};

        repeat (5) @(negedge clk);
        check("rst_ser_tx", 32'(ser_tx), 32'h1);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdt", rdt, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            wb(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, r);
            if (!vecs[i].we) check($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // TX frame of 0x55 at DIV=8, with a second write queued at cycle 20 of the frame
        txb = 8'h55;
        wr(4'h0, 32'h55, 4'hF);
        for (int i = 0; i <= 81; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 80) check($sformatf("tx_bit%0d", i), 32'(ser_tx), 32'(frame_bit(txb, 1'b1, i / 8)));
            if (i > 20) check($sformatf("tx_hold_ack%0d", i), 32'(ack), 32'(i == 81));
            if (i == 20) begin
                adr = 4'h0; we = 1'b1; dat = 32'hC3; sel = 4'hF; cyc = 1'b1;
            end
            if (i == 81) begin
                check("tx_second_start", 32'(ser_tx), 32'h0);
                cyc = 1'b0; we = 1'b0;
            end
        end
        repeat (90) @(negedge clk);

        send_byte(8'hA3, 1'b1, 8);
        rd(4'h4, r); check("rx_status_fill1", r, 32'h0000_0101);
        rd(4'h0, r); check("rx_data_a3", r, 32'h0000_00A3);
        rd(4'h0, r); check("rx_data_empty", r, 32'h8000_0000);
        void'(mq.pop_front());

        for (int b = 0; b <= 16; b++) send_byte(8'(b), 1'b1, 8);
        rd(4'h4, r); check("ovr_status", r, 32'h0000_100B);
        m_ovr = 1'b0;
        read_data_chk("ovr_first_pop");
        rd(4'h4, r); check("ovr_cleared", r, 32'h0000_0F01);

        send_byte(8'h20, 1'b1, 8);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            ser_rx = frame_bit(8'h21, 1'b1, i / 8);
            if (i == 78) begin
                adr = 4'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1;
            end
            if (i == 79) begin
                check("fullpp_ack", 32'(ack), 32'h1);
                check("fullpp_pop", rdt, 32'h0000_0001);
                cyc = 1'b0;
            end
        end
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
        void'(mq.pop_front());
        mq.push_back(8'h21);
        rd(4'h4, r); check("fullpp_status", r, 32'h0000_1003);
        while (mq.size() != 0) read_data_chk("drain");
        read_data_chk("drain_empty");

        send_byte(8'h7E, 1'b0, 8);
        rd(4'h4, r); check("frame_err", r, 32'h0000_0010);
        m_ferr = 1'b0;
        rd(4'h4, r); check("frame_err_clr", r, 32'h0);
        @(negedge clk); ser_rx = 1'b0;
        repeat (2) @(negedge clk); ser_rx = 1'b1;
        repeat (100) @(negedge clk);
        rd(4'h4, r); check("glitch_status", r, 32'h0);
        read_data_chk("glitch_empty");

`ifdef ROCKETCPU_UART_RX_IRQ_EN
        wr(4'hC, 32'h0000_0401, 4'hF);
        for (int b = 0; b < 3; b++) send_byte(8'(b + 8'h40), 1'b1, 8);
        check("irq_below_thr", 32'(irq), 32'h0);
        drive_frame(8'h43, 1'b1, 8);
        check("irq_push4_same", 32'(irq), 32'h0);
        @(negedge clk);
        ser_rx = 1'b1;
        check("irq_rise", 32'(irq), 32'h1);
        repeat (4) @(negedge clk);
        m_rx(8'h43, 1'b1);
        read_data_chk("irq_pop");
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'h0);
        while (mq.size() != 0) read_data_chk("irq_drain");
        wr(4'hC, 32'h0, 4'hF);
`endif

        for (int i = 0; i < 40; i++) begin
            int op;
            if (i % 10 == 0) begin
                per = 8 + 4 * int'($urandom_range(0, 2));
                wr(4'h8, 32'(per), 4'hF);
            end
            op = int'($urandom_range(0, 99));
            if (op < 55) send_byte(8'($urandom), ($urandom_range(0, 9) != 0), per);
            else if (op < 80) read_data_chk($sformatf("rnd_data%0d", i));
            else read_stat_chk($sformatf("rnd_stat%0d", i));
        end
        read_stat_chk("rnd_final_stat");
        while (mq.size() != 0) read_data_chk("rnd_drain");
        read_data_chk("rnd_drain_empty");

        wr(4'h8, 32'h8, 4'hF);
        wr(4'h0, 32'h00, 4'hF);
        repeat (2) @(negedge clk);
        check("midframe_start", 32'(ser_tx), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_ser_tx", 32'(ser_tx), 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(4'h8, r); check("rst_div_default", r, 32'd104);
        read_stat_chk("rst_status");
        check("rst_idle_tx", 32'(ser_tx), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
